isp_cmd_parser: RTL and testbench
=================================

Name: isp_cmd_parser

Overview:
- Byte-stream command parser that sits directly upstream of the ISP control register bank.
- Consumes bytes from the host link receiver (UART/SPI byte interface, one byte per rx_valid strobe). Frames them into register write commands and drives the register bank's wr_en/wr_addr/wr_data write port.
- Rejects malformed, out-of-range and stalled frames, and reports errors to a status/debug readout.

Parameters:
- REG_NUM, 16, number of writable registers; a frame with address >= REG_NUM is rejected.
- TIMEOUT_CYC, 1000000, consecutive idle clk cycles mid-frame before the frame is aborted; 0 disables the timeout.
- SYNC0, 8'h55, first sync byte.
- SYNC1, 8'hAA, second sync byte.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- rx_data  input  8  received byte
- wr_en  output  1  one-cycle register write strobe
- wr_addr  output  16  register address, held stable between writes
- wr_data  output  16  register data, held stable between writes
- frame_err  output  1  one-cycle pulse on any rejected frame
- last_err  output  2  0 none, 1 checksum, 2 address range, 3 timeout; holds until next error
- err_cnt  output  8  saturating count of rejected frames
- busy  output  1  high whenever the FSM is not in S_SYNC0

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk. All state updates occur on the rising edge of clk.
- Reset values:
  - FSM = S_SYNC0.
  - wr_en, frame_err, busy = 0.
  - wr_addr, wr_data = 0.
  - last_err = 0, err_cnt = 0, timeout counter = 0.
  - Any partial frame is discarded.
  - Reset asserted mid-frame behaves identically.
- Frame format: SYNC0, SYNC1, ADDR_H, ADDR_L, DATA_H, DATA_L, CSUM.
  - CSUM = (ADDR_H + ADDR_L + DATA_H + DATA_L) mod 256.
  - Sync bytes are not included in the checksum.
- FSM states: S_SYNC0, S_SYNC1, S_AH, S_AL, S_DH, S_DL, S_CS. Transitions happen only on cycles with rx_valid = 1; otherwise state holds, subject to timeout.
  - S_SYNC0: byte == SYNC0 -> S_SYNC1; any other byte stays in S_SYNC0. Not an error.
  - S_SYNC1:
    - byte == SYNC1 -> S_AH.
    - byte == SYNC0 -> stay in S_SYNC1 (resync on repeated 0x55).
    - any other byte -> S_SYNC0.
    - None of these is an error.
  - S_AH -> S_AL -> S_DH -> S_DL -> S_CS. Each state captures its byte into an internal shadow register and accumulates the 8-bit checksum.
  - S_CS -> S_SYNC0 always. Evaluation order:
    1. CSUM mismatch -> error 1.
    2. Otherwise, address >= REG_NUM -> error 2.
    3. Otherwise, the frame is a valid write.
- Valid write:
  - wr_en = 1 for exactly one cycle, the cycle immediately after the rx_valid cycle carrying CSUM (latency 1 clk).
  - wr_addr and wr_data update on the same edge and hold their values until the next valid write.
  - Rejected frames never change wr_addr or wr_data.
- Error handling:
  - frame_err pulses for one cycle, with the same timing as wr_en.
  - last_err updates on the same edge.
  - err_cnt increments on the same edge, saturating at 255.
  - wr_en stays 0.
- Timeout:
  - The counter increments on each cycle with busy = 1 and rx_valid = 0, and clears on any rx_valid or in S_SYNC0.
  - When the counter reaches TIMEOUT_CYC, the FSM goes to S_SYNC0 and error 3 is reported. frame_err pulses the following cycle.
  - If rx_valid coincides with the expiry cycle, the byte wins: it is processed normally and the counter clears.
  - With TIMEOUT_CYC = 0 the timeout never fires.
- Back-to-back frames: a new SYNC0 is accepted on the cycle right after CSUM. wr_en and frame_err from the previous frame may overlap with it.
- busy and the FSM state are registered; all outputs are registered with no combinational path from rx_* to outputs.

Test Plan:
- Valid frame: 55 AA 00 06 01 00 07 -> wr_en high exactly 1 cycle after the CSUM strobe; wr_addr = 0x0006, wr_data = 0x0100; frame_err = 0; values still held 50 cycles later.
- Bad checksum: 55 AA 00 06 01 00 08 -> no wr_en; frame_err pulse; last_err = 1; err_cnt = 1; wr_addr/wr_data unchanged from the previous write.
- Range error (REG_NUM = 16): 55 AA 00 10 12 34 56 -> no wr_en; last_err = 2. Then 55 55 AA 00 0F FF FF 0D -> resync succeeds; wr_addr = 0x000F, wr_data = 0xFFFF.
- Timeout (TIMEOUT_CYC = 20): send 55 AA 00, then idle 20 cycles -> busy drops; last_err = 3; frame_err pulse. Repeat with a byte on exactly the 20th idle cycle -> no timeout. A following full valid frame writes correctly.
- Reset mid-frame: 55 AA 00 05, assert reset 1 cycle, then 01 00 05 -> no write. Afterwards all outputs are 0 and a full frame writes normally.
- Saturation: send 260 bad-checksum frames back-to-back with rx_valid every cycle -> err_cnt stops at 255; 260 frame_err pulses observed; no wr_en.

Source files
------------

// File: rtl/isp_cmd_parser.sv
// Host byte-stream command parser: frames SYNC0 SYNC1 AH AL DH DL CSUM into
// register-bank writes, rejecting bad-checksum, out-of-range and stalled frames.
//
// state   | meaning
// S_SYNC0 | idle, hunting for first sync byte
// S_SYNC1 | first sync seen, expecting second (repeated SYNC0 keeps waiting)
// S_AH    | expecting address high byte
// S_AL    | expecting address low byte
// S_DH    | expecting data high byte
// S_DL    | expecting data low byte
// S_CS    | expecting checksum; frame is judged on this byte
module isp_cmd_parser #(
   parameter int          REG_NUM     = 16,
   parameter int          TIMEOUT_CYC = 1000000,
   parameter logic [7:0]  SYNC0       = 8'h55,
   parameter logic [7:0]  SYNC1       = 8'hAA
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [15:0] wr_data,
   output logic        frame_err,
   output logic [1:0]  last_err,
   output logic [7:0]  err_cnt,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_SYNC0 = 3'd0,
      S_SYNC1 = 3'd1,
      S_AH    = 3'd2,
      S_AL    = 3'd3,
      S_DH    = 3'd4,
      S_DL    = 3'd5,
      S_CS    = 3'd6
   } state_t;

   localparam logic [1:0]  ERR_NONE    = 2'd0;
   localparam logic [1:0]  ERR_CSUM    = 2'd1;
   localparam logic [1:0]  ERR_RANGE   = 2'd2;
   localparam logic [1:0]  ERR_TIMEOUT = 2'd3;

   localparam int              TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [16:0]     REG_LIM = 17'(REG_NUM);

   state_t          state;
   logic [15:0]     addr_sh;
   logic [15:0]     data_sh;
   logic [7:0]      csum;
   logic [TO_W-1:0] to_cnt;
   logic            to_expire;
   logic [1:0]      err_now;
   logic            wr_ok;

   assign to_expire = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);

   // Frame verdict for this cycle; checksum is judged before address range.
   always_comb begin
      err_now = ERR_NONE;
      wr_ok   = 1'b0;
      if (rx_valid) begin
         if (state == S_CS) begin
            if (rx_data != csum)
               err_now = ERR_CSUM;
            else if ({1'b0, addr_sh} >= REG_LIM)
               err_now = ERR_RANGE;
            else
               wr_ok = 1'b1;
         end
      end else if (state != S_SYNC0 && to_expire) begin
         err_now = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_SYNC0;
         busy      <= 1'b0;
         addr_sh   <= '0;
         data_sh   <= '0;
         csum      <= '0;
         to_cnt    <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_err <= 1'b0;
         last_err  <= ERR_NONE;
         err_cnt   <= '0;
      end else begin
         wr_en     <= wr_ok;
         frame_err <= (err_now != ERR_NONE);
         if (wr_ok) begin
            wr_addr <= addr_sh;
            wr_data <= data_sh;
         end
         if (err_now != ERR_NONE) begin
            last_err <= err_now;
            if (err_cnt != 8'hFF)
               err_cnt <= err_cnt + 8'd1;
         end

         if (rx_valid) begin
            to_cnt <= '0;
            case (state)
               S_SYNC0: begin
                  if (rx_data == SYNC0) begin
                     state <= S_SYNC1;
                     busy  <= 1'b1;
                  end
               end
               S_SYNC1: begin
                  if (rx_data == SYNC1) begin
                     state <= S_AH;
                  end else if (rx_data != SYNC0) begin
                     state <= S_SYNC0;
                     busy  <= 1'b0;
                  end
               end
               S_AH: begin
                  addr_sh[15:8] <= rx_data;
                  csum          <= rx_data;
                  state         <= S_AL;
               end
               S_AL: begin
                  addr_sh[7:0] <= rx_data;
                  csum         <= csum + rx_data;
                  state        <= S_DH;
               end
               S_DH: begin
                  data_sh[15:8] <= rx_data;
                  csum          <= csum + rx_data;
                  state         <= S_DL;
               end
               S_DL: begin
                  data_sh[7:0] <= rx_data;
                  csum         <= csum + rx_data;
                  state        <= S_CS;
               end
               default: begin
                  state <= S_SYNC0;
                  busy  <= 1'b0;
               end
            endcase
         end else if (state != S_SYNC0) begin
            // A byte on the expiry cycle takes the rx_valid branch above instead.
            if (to_expire) begin
               state  <= S_SYNC0;
               busy   <= 1'b0;
               to_cnt <= '0;
            end else begin
               to_cnt <= to_cnt + TO_W'(1);
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_isp_cmd_parser.sv
// Bench for isp_cmd_parser: directed scenarios plus random byte streams, all
// checked cycle-by-cycle against a frame-level reference model.
module tb_isp_cmd_parser;

   localparam int TO = 20;
   localparam int RN = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        frame_err;
   logic [1:0]  last_err;
   logic [7:0]  err_cnt;
   logic        busy;

   isp_cmd_parser #(.REG_NUM(RN), .TIMEOUT_CYC(TO), .SYNC0(8'h55), .SYNC1(8'hAA)) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err),
      .last_err(last_err), .err_cnt(err_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: sync flag, collected payload bytes, idle counter
   bit          m_sync;
   bit          m_in;
   logic [7:0]  m_q[$];
   int          m_idle;
   int          m_nwr = 0;
   int          m_nfe = 0;
   logic        e_wr_en, e_frame_err, e_busy;
   logic [15:0] e_wr_addr, e_wr_data;
   logic [1:0]  e_last_err;
   logic [7:0]  e_err_cnt;

   // observations
   int    cyc_bad = 0;
   string first_bad = "";
   int    n_wr = 0;
   int    n_fe = 0;

   task automatic model_reset();
      m_sync = 0; m_in = 0; m_q.delete(); m_idle = 0;
      e_wr_en = 0; e_frame_err = 0; e_busy = 0;
      e_wr_addr = 0; e_wr_data = 0; e_last_err = 0; e_err_cnt = 0;
   endtask

   task automatic m_err(input logic [1:0] code);
      e_frame_err = 1;
      e_last_err  = code;
      if (e_err_cnt < 8'd255) e_err_cnt = e_err_cnt + 8'd1;
      m_nfe++;
   endtask

   task automatic model_step(input bit v, input logic [7:0] d);
      bit busy_now;
      int s;
      busy_now    = m_sync || m_in;
      e_wr_en     = 0;
      e_frame_err = 0;
      if (v) begin
         m_idle = 0;
         if (m_in) begin
            m_q.push_back(d);
            if (m_q.size() == 5) begin
               s = int'(m_q[0]) + int'(m_q[1]) + int'(m_q[2]) + int'(m_q[3]);
               if ((s % 256) != int'(m_q[4]))
                  m_err(2'd1);
               else if (int'({m_q[0], m_q[1]}) >= RN)
                  m_err(2'd2);
               else begin
                  e_wr_en   = 1;
                  e_wr_addr = {m_q[0], m_q[1]};
                  e_wr_data = {m_q[2], m_q[3]};
                  m_nwr++;
               end
               m_in = 0;
               m_q.delete();
            end
         end else if (m_sync) begin
            if (d == 8'hAA) begin
               m_in = 1; m_sync = 0;
            end else if (d != 8'h55) begin
               m_sync = 0;
            end
         end else if (d == 8'h55) begin
            m_sync = 1;
         end
      end else if (busy_now) begin
         m_idle++;
         if (m_idle == TO) begin
            m_err(2'd3);
            m_sync = 0; m_in = 0; m_q.delete(); m_idle = 0;
         end
      end
      e_busy = m_sync || m_in;
   endtask

   task automatic sample();
      if ({wr_en, frame_err, busy, wr_addr, wr_data, last_err, err_cnt} !==
          {e_wr_en, e_frame_err, e_busy, e_wr_addr, e_wr_data, e_last_err, e_err_cnt}) begin
         cyc_bad++;
         if (first_bad == "")
            first_bad = $sformatf("t=%0t got we=%b fe=%b bsy=%b a=%h d=%h le=%0d ec=%0d want we=%b fe=%b bsy=%b a=%h d=%h le=%0d ec=%0d",
               $time, wr_en, frame_err, busy, wr_addr, wr_data, last_err, err_cnt,
               e_wr_en, e_frame_err, e_busy, e_wr_addr, e_wr_data, e_last_err, e_err_cnt);
      end
      if (wr_en === 1'b1) n_wr++;
      if (frame_err === 1'b1) n_fe++;
   endtask

   task automatic step(input bit v, input logic [7:0] d);
      rx_valid = v;
      rx_data  = v ? d : 8'($urandom);
      model_step(v, d);
      @(posedge clk);
      #1;
      sample();
   endtask

   task automatic do_reset();
      reset    = 1;
      rx_valid = 0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 0;
      sample();
   endtask

   task automatic send7(input logic [55:0] f);
      for (int i = 6; i >= 0; i--) step(1, f[i*8 +: 8]);
   endtask

   task automatic test_reset();
      cyc_bad = 0; first_bad = "";
      do_reset();
      do_reset();
      n_chk++;
      if ({wr_en, frame_err, busy, wr_addr, wr_data, last_err, err_cnt} !== 45'd0)
         $display("FAIL reset_state got we=%b fe=%b bsy=%b a=%h d=%h le=%0d ec=%0d want all zero",
            wr_en, frame_err, busy, wr_addr, wr_data, last_err, err_cnt);
      else n_pass++;
      repeat (3) step(0, 0);
      n_chk++;
      if (cyc_bad !== 0) $display("FAIL reset_model mismatches=%0d want 0 first: %s", cyc_bad, first_bad);
      else n_pass++;
   endtask

   task automatic test_valid_frame();
      int wr0;
      cyc_bad = 0; first_bad = "";
      wr0 = n_wr;
      send7(56'h55AA0006010007);
      n_chk++;
      if (wr_en !== 1'b1 || frame_err !== 1'b0 || wr_addr !== 16'h0006 || wr_data !== 16'h0100)
         $display("FAIL valid_write got we=%b fe=%b a=%h d=%h want we=1 fe=0 a=0006 d=0100",
            wr_en, frame_err, wr_addr, wr_data);
      else n_pass++;
      repeat (50) step(0, 0);
      n_chk++;
      if (wr_addr !== 16'h0006 || wr_data !== 16'h0100 || n_wr - wr0 !== 1)
         $display("FAIL valid_hold got a=%h d=%h pulses=%0d want a=0006 d=0100 pulses=1",
            wr_addr, wr_data, n_wr - wr0);
      else n_pass++;
      n_chk++;
      if (cyc_bad !== 0) $display("FAIL valid_model mismatches=%0d want 0 first: %s", cyc_bad, first_bad);
      else n_pass++;
   endtask

   task automatic test_bad_csum();
      int wr0;
      cyc_bad = 0; first_bad = "";
      wr0 = n_wr;
      send7(56'h55AA0006010008);
      n_chk++;
      if (frame_err !== 1'b1 || wr_en !== 1'b0 || last_err !== 2'd1 || err_cnt !== 8'd1 ||
          wr_addr !== 16'h0006 || wr_data !== 16'h0100 || n_wr !== wr0)
         $display("FAIL bad_csum got fe=%b we=%b le=%0d ec=%0d a=%h d=%h want fe=1 we=0 le=1 ec=1 a=0006 d=0100",
            frame_err, wr_en, last_err, err_cnt, wr_addr, wr_data);
      else n_pass++;
      step(0, 0);
      n_chk++;
      if (cyc_bad !== 0) $display("FAIL csum_model mismatches=%0d want 0 first: %s", cyc_bad, first_bad);
      else n_pass++;
   endtask

   task automatic test_range();
      cyc_bad = 0; first_bad = "";
      send7(56'h55AA0010123456);
      n_chk++;
      if (frame_err !== 1'b1 || wr_en !== 1'b0 || last_err !== 2'd2 || wr_addr !== 16'h0006)
         $display("FAIL range_err got fe=%b we=%b le=%0d a=%h want fe=1 we=0 le=2 a=0006",
            frame_err, wr_en, last_err, wr_addr);
      else n_pass++;
      step(1, 8'h55);
      send7(56'h55AA000FFFFF0D);
      n_chk++;
      if (wr_en !== 1'b1 || wr_addr !== 16'h000F || wr_data !== 16'hFFFF)
         $display("FAIL resync_write got we=%b a=%h d=%h want we=1 a=000f d=ffff", wr_en, wr_addr, wr_data);
      else n_pass++;
      step(0, 0);
      n_chk++;
      if (cyc_bad !== 0) $display("FAIL range_model mismatches=%0d want 0 first: %s", cyc_bad, first_bad);
      else n_pass++;
   endtask

   task automatic test_timeout();
      cyc_bad = 0; first_bad = "";
      step(1, 8'h55); step(1, 8'hAA); step(1, 8'h00);
      repeat (TO - 1) step(0, 0);
      n_chk++;
      if (busy !== 1'b1 || frame_err !== 1'b0)
         $display("FAIL timeout_early got bsy=%b fe=%b want bsy=1 fe=0", busy, frame_err);
      else n_pass++;
      step(0, 0);
      n_chk++;
      if (busy !== 1'b0 || frame_err !== 1'b1 || last_err !== 2'd3)
         $display("FAIL timeout_fire got bsy=%b fe=%b le=%0d want bsy=0 fe=1 le=3", busy, frame_err, last_err);
      else n_pass++;
      step(1, 8'h55); step(1, 8'hAA); step(1, 8'h00);
      repeat (TO - 1) step(0, 0);
      step(1, 8'h06);
      n_chk++;
      if (busy !== 1'b1 || frame_err !== 1'b0)
         $display("FAIL timeout_byte_wins got bsy=%b fe=%b want bsy=1 fe=0", busy, frame_err);
      else n_pass++;
      step(1, 8'h01); step(1, 8'h00); step(1, 8'h07);
      n_chk++;
      if (wr_en !== 1'b1 || wr_addr !== 16'h0006 || wr_data !== 16'h0100 || last_err !== 2'd3)
         $display("FAIL timeout_then_write got we=%b a=%h d=%h le=%0d want we=1 a=0006 d=0100 le=3",
            wr_en, wr_addr, wr_data, last_err);
      else n_pass++;
      step(0, 0);
      n_chk++;
      if (cyc_bad !== 0) $display("FAIL timeout_model mismatches=%0d want 0 first: %s", cyc_bad, first_bad);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int wr0;
      cyc_bad = 0; first_bad = "";
      step(1, 8'h55); step(1, 8'hAA); step(1, 8'h00); step(1, 8'h05);
      do_reset();
      wr0 = n_wr;
      step(1, 8'h01); step(1, 8'h00); step(1, 8'h05);
      step(0, 0);
      n_chk++;
      if ({wr_en, frame_err, busy, wr_addr, wr_data, last_err, err_cnt} !== 45'd0 || n_wr !== wr0)
         $display("FAIL reset_mid got we=%b fe=%b bsy=%b a=%h d=%h le=%0d ec=%0d want all zero",
            wr_en, frame_err, busy, wr_addr, wr_data, last_err, err_cnt);
      else n_pass++;
      send7(56'h55AA0003123449);
      n_chk++;
      if (wr_en !== 1'b1 || wr_addr !== 16'h0003 || wr_data !== 16'h1234)
         $display("FAIL reset_then_write got we=%b a=%h d=%h want we=1 a=0003 d=1234", wr_en, wr_addr, wr_data);
      else n_pass++;
      step(0, 0);
      n_chk++;
      if (cyc_bad !== 0) $display("FAIL reset_mid_model mismatches=%0d want 0 first: %s", cyc_bad, first_bad);
      else n_pass++;
   endtask

   task automatic test_back_to_back_saturation();
      int fe0, wr0;
      cyc_bad = 0; first_bad = "";
      do_reset();
      fe0 = n_fe; wr0 = n_wr;
      for (int i = 0; i < 260; i++) send7(56'h55AA00010000FF);
      step(0, 0);
      n_chk++;
      if (err_cnt !== 8'd255 || n_fe - fe0 !== 260 || n_wr !== wr0 || last_err !== 2'd1)
         $display("FAIL saturation got ec=%0d fe_pulses=%0d we_pulses=%0d le=%0d want ec=255 fe_pulses=260 we_pulses=0 le=1",
            err_cnt, n_fe - fe0, n_wr - wr0, last_err);
      else n_pass++;
      n_chk++;
      if (cyc_bad !== 0) $display("FAIL saturation_model mismatches=%0d want 0 first: %s", cyc_bad, first_bad);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0] fb [7];
      int k, gap_pos;
      cyc_bad = 0; first_bad = "";
      do_reset();
      for (int it = 0; it < 300; it++) begin
         k = $urandom_range(0, 9);
         if (k == 0) begin
            step(1, ($urandom_range(0, 2) == 0) ? 8'h55 : 8'($urandom));
         end else if (k == 1) begin
            repeat ($urandom_range(1, 25)) step(0, 0);
         end else begin
            fb[0] = 8'h55;
            fb[1] = 8'hAA;
            fb[2] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            fb[3] = 8'($urandom_range(0, 31));
            fb[4] = 8'($urandom);
            fb[5] = 8'($urandom);
            fb[6] = 8'((int'(fb[2]) + int'(fb[3]) + int'(fb[4]) + int'(fb[5])) % 256);
            if ($urandom_range(0, 4) == 0) fb[6] = fb[6] ^ 8'(1 << $urandom_range(0, 7));
            gap_pos = $urandom_range(0, 12);
            for (int i = 0; i < 7; i++) begin
               step(1, fb[i]);
               if (i == gap_pos && i < 6) repeat ($urandom_range(1, 22)) step(0, 0);
            end
         end
      end
      step(0, 0);
      n_chk++;
      if (cyc_bad !== 0) $display("FAIL random_model mismatches=%0d want 0 first: %s", cyc_bad, first_bad);
      else n_pass++;
      n_chk++;
      if (n_wr !== m_nwr || n_fe !== m_nfe)
         $display("FAIL random_pulse_totals got we=%0d fe=%0d want we=%0d fe=%0d", n_wr, n_fe, m_nwr, m_nfe);
      else n_pass++;
   endtask

   initial begin
      reset    = 1;
      rx_valid = 0;
      rx_data  = 0;
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_valid_frame();
      test_bad_csum();
      test_range();
      test_timeout();
      test_reset_mid();
      test_back_to_back_saturation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
